core_inst_seq: RTL and testbench

CORE_INST_SEQ -- requirements
Module: core_inst_seq

---
 rtl/core_inst_pkg.sv | 43 ++++
 rtl/core_inst_dly.sv | 32 +++
 rtl/core_inst_seq.sv | 198 +++++++++++++++++++
 tb/tb_core_inst_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_inst_pkg.sv
// Shared definitions for the conv-pass instruction sequencer: instruction-word
// bit positions, the idle word and the sequencer state encoding.
package core_inst_pkg;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Memories deselected, write-enables inactive, every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_RD,
        ST_W_LD,
        ST_GAP,
        ST_X_EX,
        ST_DRAIN,
        ST_NEXT,
        ST_FIN
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/core_inst_dly.sv
// One-cycle delay of a strobe plus its payload; the payload reads as zero
// whenever the delayed strobe is low so it can drive instruction fields directly.
module core_inst_dly
    import core_inst_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_srst,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            r_vld  <= i_vld;
            r_data <= i_vld ? i_data : '0;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/core_inst_seq.sv
// Conv-pass instruction sequencer: per kernel position loads weights into the
// array, streams activations, then drains the output FIFO into pmem.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int          bw      = 4,
    parameter int          psum_bw = 16,
    parameter int          row     = 8,
    parameter int          col     = 8,
    parameter int          len_kij = 9,
    parameter int          len_nij = 36,
    parameter logic [10:0] w_base  = 11'd64,
    parameter logic [10:0] p_base  = 11'd0,
    parameter int          gap     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max3(len_nij, col, gap) + 1);
    localparam int KIJ_W = $clog2(len_kij + 1);

    localparam logic [CNT_W-1:0]  COL_C    = CNT_W'(col);
    localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(gap - 1);
    localparam logic [CNT_W-1:0]  NIJ_LAST = CNT_W'(len_nij - 1);
    localparam logic [KIJ_W-1:0]  KIJ_LAST = KIJ_W'(len_kij - 1);
    localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(col);

    if (bw < 1 || psum_bw < bw || row < 1 || col < 1 || len_kij < 1 || len_nij < 1 || gap < 1) begin : g_bad_cfg
        $error("core_inst_seq: inconsistent array configuration");
    end

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [KIJ_W-1:0]    r_kij, w_kij_next;
    logic [INST_W-1:0]   r_inst, w_inst_next;
    logic                r_busy, r_done, r_ex_pend;

    logic                w_xrd, w_ld, w_ofifo_rd, w_is_x;
    logic [ADDR_W-1:0]   w_xaddr;
    logic                w_l0wr, w_l0wr_x, w_pwr;
    logic [ADDR_W:0]     w_pdata_in, w_pdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_kij_next   = r_kij;
        w_xrd        = 1'b0;
        w_xaddr      = '0;
        w_ld         = 1'b0;
        w_ofifo_rd   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_W_RD;
                    w_cnt_next   = '0;
                    w_kij_next   = '0;
                end
            end
            // One extra cycle after the last read lets its delayed l0_wr
            // land before load begins.
            ST_W_RD: begin
                if (r_cnt < COL_C) begin
                    w_xrd      = 1'b1;
                    w_xaddr    = w_base + ADDR_W'(r_kij) * COL_A + ADDR_W'(r_cnt);
                    w_cnt_next = r_cnt + 1'b1;
                end else begin
                    w_state_next = ST_W_LD;
                    w_cnt_next   = '0;
                end
            end
            ST_W_LD: begin
                w_ld = 1'b1;
                if (r_cnt == COL_LAST) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = ST_X_EX;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_X_EX: begin
                w_xrd   = 1'b1;
                w_xaddr = ADDR_W'(r_cnt);
                if (r_cnt == NIJ_LAST) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (valid) begin
                    w_ofifo_rd = 1'b1;
                    if (r_cnt == NIJ_LAST) begin
                        w_state_next = ST_NEXT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if (r_kij == KIJ_LAST) begin
                    w_state_next = ST_FIN;
                end else begin
                    w_kij_next   = r_kij + 1'b1;
                    w_state_next = ST_W_RD;
                    w_cnt_next   = '0;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The payload bit marks activation reads, whose l0_wr spawns an execute.
    assign w_is_x     = (r_state == ST_X_EX);
    assign w_pdata_in = {(r_kij != '0), p_base + ADDR_W'(r_cnt)};

    core_inst_dly #(.W(1)) u_dly_l0 (
        .clk    (clk),
        .i_srst (reset),
        .i_vld  (w_xrd),
        .i_data (w_is_x),
        .o_vld  (w_l0wr),
        .o_data (w_l0wr_x)
    );

    core_inst_dly #(.W(ADDR_W + 1)) u_dly_pmem (
        .clk    (clk),
        .i_srst (reset),
        .i_vld  (w_ofifo_rd),
        .i_data (w_pdata_in),
        .o_vld  (w_pwr),
        .o_data (w_pdata)
    );

    always_comb begin
        w_inst_next                        = INST_IDLE;
        w_inst_next[B_ACC]                 = w_pdata[ADDR_W];
        w_inst_next[B_CEN_P]               = ~w_pwr;
        w_inst_next[B_WEN_P]               = ~w_pwr;
        w_inst_next[B_AP_LO +: ADDR_W]     = w_pdata[ADDR_W-1:0];
        w_inst_next[B_CEN_X]               = ~w_xrd;
        w_inst_next[B_WEN_X]               = 1'b1;
        w_inst_next[B_AX_LO +: ADDR_W]     = w_xaddr;
        w_inst_next[B_OFIFO_RD]            = w_ofifo_rd;
        w_inst_next[B_IFIFO_WR]            = 1'b0;
        w_inst_next[B_IFIFO_RD]            = 1'b0;
        w_inst_next[B_L0_RD]               = w_ld | r_ex_pend;
        w_inst_next[B_L0_WR]               = w_l0wr;
        w_inst_next[B_EXEC]                = r_ex_pend;
        w_inst_next[B_LOAD]                = w_ld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_kij     <= '0;
            r_inst    <= INST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ex_pend <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_kij     <= w_kij_next;
            r_inst    <= w_inst_next;
            r_busy    <= (w_state_next != ST_IDLE) && (w_state_next != ST_FIN);
            r_done    <= (w_state_next == ST_FIN);
            r_ex_pend <= w_l0wr & w_l0wr_x;
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: stimulus queues expected xmem reads and
// pmem writes; a negedge monitor decodes inst and checks strobe timing.
module tb_core_inst_seq;
    import core_inst_pkg::*;

    typedef struct {
        logic [10:0] addr;
        bit          act;
    } xrd_t;

    typedef struct {
        logic        acc;
        logic [10:0] addr;
    } pw_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              valid = 1'b0;
    logic [INST_W-1:0] inst;
    logic              busy, done;

    always #5 clk = ~clk;

    core_inst_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .valid (valid),
        .inst  (inst),
        .busy  (busy),
        .done  (done)
    );

    int   n_checks = 0;
    int   n_err = 0;
    xrd_t q_xrd[$];
    pw_t  q_pw[$];
    int   vmode = 0;
    int   n_exec = 0, n_load = 0, n_ofifo = 0, n_done = 0;
    bit   seen17 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // valid pattern 1,0,1,1,0,1... (mode 0) or held high (mode 1)
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            valid = (vmode == 1) ? 1'b1 : ((cyc % 3) != 1);
        end
    end

    // Monitor
    logic exp_l0wr = 0, exp_l0act = 0, exp_exec = 0;
    logic prev_ofifo = 0, prev_valid = 0, prev_load = 0, prev_l0wr = 0, prev_done = 0;
    bit   gap_on = 0;
    int   load_run = 0, gap_cnt = 0;

    always @(negedge clk) begin
        logic xrd, l0wr, l0rd, exe, ld, ofrd, pw, cur_act;
        xrd_t e;
        pw_t  p;
        if (reset) begin
            exp_l0wr = 0; exp_l0act = 0; exp_exec = 0;
            prev_ofifo = 0; prev_valid = 0; prev_load = 0; prev_l0wr = 0; prev_done = 0;
            gap_on = 0; load_run = 0; gap_cnt = 0;
        end else begin
            xrd  = ~inst[B_CEN_X];
            l0wr = inst[B_L0_WR];
            l0rd = inst[B_L0_RD];
            exe  = inst[B_EXEC];
            ld   = inst[B_LOAD];
            ofrd = inst[B_OFIFO_RD];
            pw   = ~inst[B_CEN_P];
            cur_act = 0;
            if (xrd) begin
                if (q_xrd.size() == 0) begin
                    check("xrd_unexpected", 64'(inst[B_AX_LO +: ADDR_W]), 64'hFFFF);
                end else begin
                    e = q_xrd.pop_front();
                    check("xrd_addr", {inst[B_WEN_X], inst[B_AX_LO +: ADDR_W]}, {1'b1, e.addr});
                    cur_act = e.act;
                    if (e.act && e.addr == 11'd17) seen17 = 1;
                end
            end
            if (l0wr || exp_l0wr) check("l0_wr_lag", l0wr, exp_l0wr);
            if (exe || exp_exec) check("exec_lag", {exe, l0rd}, {exp_exec, 1'b1});
            if (exe) n_exec++;
            if (ld) begin
                n_load++;
                load_run++;
                check("load_l0rd", l0rd, 1);
                if (!prev_load) check("load_after_l0wr", prev_l0wr, 1);
            end
            if (!ld && prev_load) begin
                check("load_run", load_run, 8);
                load_run = 0;
                gap_on = 1;
                gap_cnt = 0;
            end
            if (gap_on) begin
                if (inst == INST_IDLE) gap_cnt++;
                else begin
                    check("gap_len", gap_cnt, 16);
                    gap_on = 0;
                end
            end
            if (ofrd) begin
                n_ofifo++;
                check("ofifo_rd_valid", prev_valid, 1);
            end
            if (pw || prev_ofifo) check("pmem_lag", pw, prev_ofifo);
            if (pw) begin
                if (q_pw.size() == 0) begin
                    check("pmem_unexpected", 64'(inst[B_AP_LO +: ADDR_W]), 64'hFFFF);
                end else begin
                    p = q_pw.pop_front();
                    check("pmem_word", {inst[B_WEN_P], inst[B_ACC], inst[B_AP_LO +: ADDR_W]},
                          {1'b0, p.acc, p.addr});
                end
            end
            if (done) begin
                n_done++;
                check("done_pulse", {busy, prev_done}, 2'b00);
            end
            exp_exec   = exp_l0wr & exp_l0act;
            exp_l0wr   = xrd;
            exp_l0act  = cur_act;
            prev_ofifo = ofrd;
            prev_valid = valid;
            prev_load  = ld;
            prev_l0wr  = l0wr;
            prev_done  = done;
        end
    end

    task automatic push_pass();
        xrd_t e;
        pw_t  p;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++) begin
                e.addr = 11'(64 + 8 * k + i);
                e.act  = 0;
                q_xrd.push_back(e);
            end
            for (int n = 0; n < 36; n++) begin
                e.addr = 11'(n);
                e.act  = 1;
                q_xrd.push_back(e);
                p.acc  = (k > 0);
                p.addr = 11'(n);
                q_pw.push_back(p);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int mode);
        int d0;
        vmode = mode;
        n_exec = 0; n_load = 0; n_ofifo = 0;
        d0 = n_done;
        push_pass();
        pulse_start();
        @(negedge clk);
        check("busy_after_start", busy, 1);
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 6000 && n_done == d0; c++) @(posedge clk);
        check("done_seen", n_done - d0, 1);
        repeat (3) @(negedge clk);
        check("busy_after_done", busy, 0);
        check("single_done", n_done - d0, 1);
        check("xrd_left", q_xrd.size(), 0);
        check("pmem_left", q_pw.size(), 0);
        check("exec_total", n_exec, 324);
        check("load_total", n_load, 72);
        check("ofifo_total", n_ofifo, 324);
        $display("pass %s: valid_mode=%0d exec=%0d load=%0d ofifo_rd=%0d dones=%0d",
                 tag, mode, n_exec, n_load, n_ofifo, n_done - d0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_inst", inst, INST_IDLE);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        repeat (3) @(negedge clk);
        check("start_in_reset_busy", busy, 0);
        check("start_in_reset_inst", inst, INST_IDLE);
        $display("reset: inst=%0h busy=%0b done=%0b", inst, busy, done);

        run_pass("backpressure", 0);
        run_pass("valid_high", 1);

        vmode = 1;
        seen17 = 0;
        push_pass();
        pulse_start();
        for (int c = 0; c < 2000 && !seen17; c++) @(posedge clk);
        check("reached_n17", seen17, 1);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset_inst", inst, INST_IDLE);
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        q_xrd.delete();
        q_pw.delete();
        @(posedge clk); #1 reset = 1'b0;
        $display("reset mid X_EX: inst=%0h busy=%0b", inst, busy);

        run_pass("restart", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
